uart_cmd_decoder: RTL and testbench

Converts the host's ASCII command stream, delivered one byte at a time by the UART receiver, into 34-bit command words for the wishbone bus master. Hex digits build up in an accumulator. A command letter then emits one word into a small FIFO. The FIFO output drives the bus master's i_cmd_stb / i_cmd_word pair and honours its o_cmd_busy.

---
 rtl/uart_cmd_decoder_if.sv | 25 ++
 rtl/uart_cmd_decoder.sv | 115 +++++++++++
 tb/tb_uart_cmd_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input from the UART receiver and command-word handshake toward the bus master.
// The master modport is the decoder's view; slave is the surrounding environment.
interface uart_cmd_decoder_if;
    logic        rx_stb;
    logic [7:0]  rx_data;
    logic        cmd_stb;
    logic [33:0] cmd_word;
    logic        cmd_busy;

    modport master (
        input  rx_stb,
        input  rx_data,
        input  cmd_busy,
        output cmd_stb,
        output cmd_word
    );

    modport slave (
        output rx_stb,
        output rx_data,
        output cmd_busy,
        input  cmd_stb,
        input  cmd_word
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: hex digits accumulate into a 32-bit value, command letters emit
// 34-bit words into a first-word-fall-through FIFO that feeds the bus master.
module uart_cmd_decoder #(
    parameter int LGFIFO = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    uart_cmd_decoder_if.master  bus,
    output logic                o_err,
    output logic                o_overflow,
    output logic [LGFIFO:0]     o_fifo_fill
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL_FILL = (LGFIFO + 1)'(DEPTH);

    logic [31:0]       acc;
    logic              is_hex;
    logic              is_space;
    logic              is_cmd;
    logic [3:0]        nibble;
    logic [33:0]       new_word;

    logic [33:0]       mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr;
    logic [LGFIFO-1:0] rd_ptr;
    logic [LGFIFO:0]   fill;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;

    always_comb begin
        is_hex   = 1'b0;
        is_space = 1'b0;
        is_cmd   = 1'b0;
        nibble   = 4'h0;
        new_word = 34'h0;
        if (bus.rx_data inside {[8'h30:8'h39]}) begin
            is_hex = 1'b1;
            nibble = bus.rx_data[3:0];
        end else if (bus.rx_data inside {[8'h41:8'h46]}) begin
            is_hex = 1'b1;
            nibble = 4'(bus.rx_data - 8'h37);
        end else if (bus.rx_data inside {[8'h61:8'h66]}) begin
            is_hex = 1'b1;
            nibble = 4'(bus.rx_data - 8'h57);
        end else begin
            case (bus.rx_data)
                8'h20, 8'h0D, 8'h0A: is_space = 1'b1;
                8'h52: begin is_cmd = 1'b1; new_word = 34'h0; end
                8'h57: begin is_cmd = 1'b1; new_word = {2'b01, acc}; end
                8'h53: begin is_cmd = 1'b1; new_word = {2'b10, 2'b00, acc[29:2], 2'b00}; end
                8'h4E: begin is_cmd = 1'b1; new_word = {2'b10, 2'b00, acc[29:2], 2'b01}; end
                8'h50: begin is_cmd = 1'b1; new_word = {2'b10, 2'b00, acc[29:2], 2'b10}; end
                8'h5A: begin is_cmd = 1'b1; new_word = {2'b11, 32'h0}; end
                default: ;
            endcase
        end
    end

    // Commands and illegal characters both leave the accumulator cleared for the next command.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc   <= 32'h0;
            o_err <= 1'b0;
        end else begin
            o_err <= bus.rx_stb && !is_hex && !is_space && !is_cmd;
            if (bus.rx_stb) begin
                if (is_hex)
                    acc <= {acc[27:0], nibble};
                else if (!is_space)
                    acc <= 32'h0;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    always_comb begin
        full     = (fill == FULL_FILL);
        pop      = (fill != '0) && !bus.cmd_busy;
        push_req = bus.rx_stb && is_cmd;
        push     = push_req && (!full || pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= push_req && !push;
            if (push)
                wr_ptr <= wr_ptr + LGFIFO'(1);
            if (pop)
                rd_ptr <= rd_ptr + LGFIFO'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (LGFIFO + 1)'(1);
                2'b01:   fill <= fill - (LGFIFO + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= new_word;
    end

    assign bus.cmd_stb  = (fill != '0);
    assign bus.cmd_word = mem[rd_ptr];
    assign o_fifo_fill  = fill;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a table of per-byte vectors with expected
// registered outputs, plus hand-written FIFO-full and reset sequences.
module tb_uart_cmd_decoder;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        busy;
        logic        exp_stb;
        logic [33:0] exp_word;
        logic        exp_err;
        logic        exp_ovf;
        logic [2:0]  exp_fill;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       err;
    logic       overflow;
    logic [2:0] fifo_fill;
    int         vectors;
    int         miscompares;
    vec_t       vecs[$];

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.LGFIFO(2)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .bus         (bus.master),
        .o_err       (err),
        .o_overflow  (overflow),
        .o_fifo_fill (fifo_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic valid, input logic [7:0] data, input logic busy,
                           input logic exp_stb, input logic [33:0] exp_word,
                           input logic exp_err, input logic exp_ovf, input logic [2:0] exp_fill);
        vec_t v;
        v.valid    = valid;
        v.data     = data;
        v.busy     = busy;
        v.exp_stb  = exp_stb;
        v.exp_word = exp_word;
        v.exp_err  = exp_err;
        v.exp_ovf  = exp_ovf;
        v.exp_fill = exp_fill;
        vecs.push_back(v);
    endtask

    // Characters sent with busy low into an empty or draining single-entry FIFO.
    task automatic add_quiet(input string s);
        for (int i = 0; i < s.len(); i++)
            add_vec(1'b1, s[i], 1'b0, 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic add_cmd(input logic [7:0] ch, input logic [33:0] word, input logic [2:0] fill);
        add_vec(1'b1, ch, 1'b0, 1'b1, word, 1'b0, 1'b0, fill);
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] data, input logic busy);
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_stb   = valid;
        bus.rx_data  = data;
        bus.cmd_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic exp_stb, input logic [33:0] exp_word,
                                input logic exp_err, input logic exp_ovf, input logic [2:0] exp_fill);
        vectors++;
        if (bus.cmd_stb !== exp_stb) begin
            miscompares++;
            $display("[TB] FAIL %s cmd_stb: got %b want %b", name, bus.cmd_stb, exp_stb);
        end
        if (exp_stb && bus.cmd_word !== exp_word) begin
            miscompares++;
            $display("[TB] FAIL %s cmd_word: got %h want %h", name, bus.cmd_word, exp_word);
        end
        if (err !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL %s err: got %b want %b", name, err, exp_err);
        end
        if (overflow !== exp_ovf) begin
            miscompares++;
            $display("[TB] FAIL %s overflow: got %b want %b", name, overflow, exp_ovf);
        end
        if (fifo_fill !== exp_fill) begin
            miscompares++;
            $display("[TB] FAIL %s fill: got %0d want %0d", name, fifo_fill, exp_fill);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.rx_stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.rx_stb   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cmd_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);

        // Address commands
        add_quiet("1234");  add_cmd("S", 34'h2_0000_1234, 3'd1);
        add_quiet("1237");  add_cmd("N", 34'h2_0000_1235, 3'd1);
        add_quiet("10");    add_cmd("P", 34'h2_0000_0012, 3'd1);
        // Writes, digit overrun, bare W (push+pop with one entry queued)
        add_quiet("DEADBEEF");  add_cmd("W", 34'h1_DEAD_BEEF, 3'd1);
        add_quiet("123456789"); add_cmd("W", 34'h1_2345_6789, 3'd1);
        add_cmd("W", 34'h1_0000_0000, 3'd1);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);
        add_quiet("ab");    add_cmd("W", 34'h1_0000_00AB, 3'd1);
        // Read, special, whitespace interleaved
        add_quiet("5");     add_cmd("R", 34'h0_0000_0000, 3'd1);
        add_cmd("Z", 34'h3_0000_0000, 3'd1);
        add_quiet(" 1\r2 3\n4 ");  add_cmd("S", 34'h2_0000_1234, 3'd1);
        add_quiet("5 \r");  add_cmd("R", 34'h0_0000_0000, 3'd1);
        add_quiet("\n ");   add_cmd("Z", 34'h3_0000_0000, 3'd1);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);
        // Busy held: fill to 4, fifth R overflows, then drain on consecutive cycles
        for (int i = 1; i <= 4; i++)
            add_vec(1'b1, "R", 1'b1, 1'b1, 34'h0, 1'b0, 1'b0, 3'(i));
        add_vec(1'b1, "R", 1'b1, 1'b1, 34'h0, 1'b0, 1'b1, 3'd4);
        add_vec(1'b0, 8'h00, 1'b1, 1'b1, 34'h0, 1'b0, 1'b0, 3'd4);
        for (int i = 3; i >= 0; i--)
            add_vec(1'b0, 8'h00, 1'b0, (i != 0), 34'h0, 1'b0, 1'b0, 3'(i));
        // Illegal character clears pending digits
        add_quiet("12");
        add_vec(1'b1, "G", 1'b0, 1'b0, 34'h0, 1'b1, 1'b0, 3'd0);
        add_cmd("W", 34'h1_0000_0000, 3'd1);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].valid, vecs[i].data, vecs[i].busy);
            check_output($sformatf("vec%0d", i), vecs[i].exp_stb, vecs[i].exp_word,
                         vecs[i].exp_err, vecs[i].exp_ovf, vecs[i].exp_fill);
        end

        // Full FIFO of distinct writes, then a W coinciding with a pop
        for (int n = 1; n <= 4; n++) begin
            apply_stimulus(1'b1, 8'h30 + 8'(n), 1'b1);
            check_output("full_digit", (n != 1), 34'h1_0000_0001, 1'b0, 1'b0, 3'(n - 1));
            apply_stimulus(1'b1, "W", 1'b1);
            check_output("full_push", 1'b1, 34'h1_0000_0001, 1'b0, 1'b0, 3'(n));
        end
        apply_stimulus(1'b1, "5", 1'b1);
        check_output("full_hold", 1'b1, 34'h1_0000_0001, 1'b0, 1'b0, 3'd4);
        apply_stimulus(1'b1, "W", 1'b0);
        check_output("full_pushpop", 1'b1, 34'h1_0000_0002, 1'b0, 1'b0, 3'd4);
        for (int n = 3; n <= 5; n++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            check_output("full_drain", 1'b1, 34'h1_0000_0000 | 34'(n), 1'b0, 1'b0, 3'(6 - n));
        end
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("full_empty", 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);

        // Reset mid-stream drops queued words and pending digits
        apply_stimulus(1'b1, "7", 1'b1);
        apply_stimulus(1'b1, "W", 1'b1);
        check_output("pre_reset_q", 1'b1, 34'h1_0000_0007, 1'b0, 1'b0, 3'd1);
        apply_stimulus(1'b1, "A", 1'b1);
        apply_stimulus(1'b1, "B", 1'b1);
        do_reset();
        check_output("mid_reset", 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);
        apply_stimulus(1'b1, "W", 1'b0);
        check_output("post_reset_w", 1'b1, 34'h1_0000_0000, 1'b0, 1'b0, 3'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("post_reset_empty", 1'b0, 34'h0, 1'b0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
